// File: rtl/riscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO feeding a serializer.
// The FIFO head is popped straight into the shift register so back-to-back frames have no gap.
module riscv_uart_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             raw_clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             tx_busy,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int AW = CNT_W - 1;
    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr, rd_ptr;
    logic [15:0]      baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       head;
    logic             tx_n;
    logic             pop;
    logic             push;
    logic             bit_end;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_count = wr_ptr - rd_ptr;
    assign tx_busy    = (state != IDLE) || !fifo_empty;

    assign head    = mem[rd_ptr[AW-1:0]];
    assign bit_end = (baud_cnt == BIT_LAST);
    // A pop on the same edge frees a slot, so a full FIFO still takes the write.
    assign push    = wr_en && (!fifo_full || pop);

    always_ff @(posedge raw_clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_en && !push)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge raw_clk) begin
        if (push && !rst)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx;
        baud_cnt_n = baud_cnt + 16'd1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    tx_n       = shift[0];
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_riscv_uart_tx.sv
// Bench for riscv_uart_tx: a fast-baud instance checked every cycle against a frame-position
// model plus directed literal checks, and a full-rate instance decoded by a bench receiver.
module tb_riscv_uart_tx;
    localparam int BA = 4;
    localparam int DA = 4;
    localparam int BB = 868;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en_a, clr_ovf_a, wr_en_b, clr_ovf_b;
    logic [7:0] wr_data_a, wr_data_b;
    logic       tx_a, busy_a, full_a, empty_a, ovf_a;
    logic       tx_b, busy_b, full_b, empty_b, ovf_b;
    logic [2:0] count_a;
    logic [3:0] count_b;

    int total = 0;
    int bad = 0;

    riscv_uart_tx #(.BAUD_DIV(BA), .FIFO_DEPTH(DA), .CNT_W(3)) dut_a (
        .raw_clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a), .clr_ovf(clr_ovf_a),
        .tx(tx_a), .tx_busy(busy_a), .fifo_full(full_a), .fifo_empty(empty_a),
        .fifo_count(count_a), .overflow(ovf_a)
    );

    riscv_uart_tx #(.BAUD_DIV(BB), .FIFO_DEPTH(8), .CNT_W(4)) dut_b (
        .raw_clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .clr_ovf(clr_ovf_b),
        .tx(tx_b), .tx_busy(busy_b), .fifo_full(full_b), .fifo_empty(empty_b),
        .fifo_count(count_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Model: a byte queue plus the position inside the frame being sent.
    byte unsigned mq[$];
    bit           m_act = 1'b0;
    int           m_pos = 0;
    logic [7:0]   m_cur = 8'h00;
    bit           m_ovf = 1'b0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        bit popped, full0, drop;
        if (rst) begin
            mq.delete();
            m_act  = 1'b0;
            m_pos  = 0;
            m_ovf  = 1'b0;
            chk_en = 1'b1;
        end else begin
            full0  = (mq.size() == DA);
            popped = 1'b0;
            if (m_act && m_pos != 10 * BA - 1) begin
                m_pos++;
            end else if (mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_act  = 1'b1;
                m_pos  = 0;
                popped = 1'b1;
            end else begin
                m_act = 1'b0;
            end
            drop = wr_en_a && full0 && !popped;
            if (wr_en_a && !drop)
                mq.push_back(wr_data_a);
            if (drop)
                m_ovf = 1'b1;
            else if (clr_ovf_a)
                m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic etx;
            int   bi;
            etx = 1'b1;
            if (m_act) begin
                bi = m_pos / BA;
                if (bi == 0)
                    etx = 1'b0;
                else if (bi < 9)
                    etx = m_cur[bi-1];
            end
            chk("model{tx,busy,full,empty,count,ovf}",
                32'({tx_a, busy_a, full_a, empty_a, count_a, ovf_a}),
                32'({etx, (m_act || mq.size() != 0), (mq.size() == DA), (mq.size() == 0),
                     3'(mq.size()), m_ovf}));
        end
    end

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Write into an idle, empty transmitter and confirm tx falls exactly one edge later.
    task automatic start_byte(input int sel, input logic [7:0] d, input string name);
        if (sel != 0) begin wr_en_b = 1'b1; wr_data_b = d; end
        else begin wr_en_a = 1'b1; wr_data_a = d; end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        chk({name, "_tx_high_after_write"}, 32'(tx_of(sel)), 32'd1);
        @(negedge clk);
        chk({name, "_tx_fall"}, 32'(tx_of(sel)), 32'd0);
    endtask

    // Starting on the first cycle of a start bit, sample each bit mid-period like a receiver.
    task automatic capture(input int sel, input int b, output logic [9:0] f,
                           output logic b_last, output logic b_after);
        f = '1;
        b_last = 1'b0;
        for (int k = 0; k < 10 * b; k++) begin
            if (k % b == b / 2)
                f[k / b] = tx_of(sel);
            if (k == 10 * b - 1)
                b_last = busy_of(sel);
            @(negedge clk);
        end
        b_after = busy_of(sel);
    endtask

    task automatic no_activity(input int sel, input int n, input string name);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx_of(sel) == 1'b0)
                lows++;
        end
        chk({name, "_no_frames"}, 32'(lows), 32'd0);
        chk({name, "_idle_busy"}, 32'(busy_of(sel)), 32'd0);
    endtask

    logic [9:0] f;
    logic       bl, ba;
    logic [7:0] q4 [4];

    initial begin
        rst = 1'b1;
        wr_en_a = 1'b0; clr_ovf_a = 1'b0; wr_data_a = 8'h00;
        wr_en_b = 1'b0; clr_ovf_b = 1'b0; wr_data_b = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_a", 32'({tx_a, busy_a, full_a, empty_a, count_a, ovf_a}), 32'b1_0_0_1_000_0);
        chk("rst_b", 32'({tx_b, busy_b, full_b, empty_b, count_b, ovf_b}), 32'b1_0_0_1_0000_0);
        rst = 1'b0;
        @(negedge clk);

        // 0x55: alternating line, tx_busy drops exactly 40 cycles after the fall.
        start_byte(0, 8'h55, "t1");
        capture(0, BA, f, bl, ba);
        chk("t1_frame", 32'(f), 32'h2AA);
        chk("t1_busy_cycle39", 32'(bl), 32'd1);
        chk("t1_busy_cycle40", 32'(ba), 32'd0);
        repeat (3) @(negedge clk);

        // Two writes on consecutive edges: contiguous frames, count peaks at 1.
        wr_en_a = 1'b1; wr_data_a = 8'hA3;
        @(negedge clk);
        wr_data_a = 8'h0F;
        @(negedge clk);
        wr_en_a = 1'b0;
        chk("t2_count_peak", 32'(count_a), 32'd1);
        chk("t2_tx_fall", 32'(tx_a), 32'd0);
        capture(0, BA, f, bl, ba);
        chk("t2_frame_a3", 32'(f), 32'h346);
        chk("t2_contiguous_start", 32'(tx_a), 32'd0);
        chk("t2_busy_between", 32'(ba), 32'd1);
        capture(0, BA, f, bl, ba);
        chk("t2_frame_0f", 32'(f), 32'h21E);
        chk("t2_busy_end", 32'(ba), 32'd0);
        repeat (3) @(negedge clk);

        // Five writes during a frame: four accepted, fifth dropped.
        q4 = '{8'h22, 8'h33, 8'h44, 8'h55};
        start_byte(0, 8'h11, "t3");
        fork
            capture(0, BA, f, bl, ba);
            begin
                for (int i = 0; i < 5; i++) begin
                    wr_en_a = 1'b1;
                    wr_data_a = (i < 4) ? q4[i] : 8'h66;
                    @(negedge clk);
                end
                wr_en_a = 1'b0;
                chk("t3_full", 32'(full_a), 32'd1);
                chk("t3_count", 32'(count_a), 32'd4);
                chk("t3_ovf_set", 32'(ovf_a), 32'd1);
                clr_ovf_a = 1'b1;
                @(negedge clk);
                clr_ovf_a = 1'b0;
                chk("t3_ovf_clr", 32'(ovf_a), 32'd0);
            end
        join
        chk("t3_frame0", 32'(f), 32'(frame_of(8'h11)));
        for (int i = 0; i < 4; i++) begin
            capture(0, BA, f, bl, ba);
            chk("t3_frame", 32'(f), 32'(frame_of(q4[i])));
        end
        chk("t3_busy_end", 32'(ba), 32'd0);
        no_activity(0, 60, "t3");

        // Full FIFO, write lands on the STOP-end pop edge.
        start_byte(0, 8'h11, "t4");
        fork
            capture(0, BA, f, bl, ba);
            begin
                for (int i = 0; i < 4; i++) begin
                    wr_en_a = 1'b1;
                    wr_data_a = q4[i];
                    @(negedge clk);
                end
                wr_en_a = 1'b0;
                repeat (35) @(negedge clk);
                chk("t4_full_before", 32'(full_a), 32'd1);
                wr_en_a = 1'b1;
                wr_data_a = 8'h77;
                @(negedge clk);
                wr_en_a = 1'b0;
                chk("t4_count", 32'(count_a), 32'd4);
                chk("t4_full_after", 32'(full_a), 32'd1);
                chk("t4_ovf", 32'(ovf_a), 32'd0);
            end
        join
        chk("t4_frame0", 32'(f), 32'(frame_of(8'h11)));
        for (int i = 0; i < 5; i++) begin
            capture(0, BA, f, bl, ba);
            chk("t4_frame", 32'(f), 32'(frame_of((i < 4) ? q4[i] : 8'h77)));
        end
        chk("t4_busy_end", 32'(ba), 32'd0);
        no_activity(0, 60, "t4");

        // Reset at cycle 15 of a frame with bytes still queued.
        start_byte(0, 8'h11, "t5");
        wr_en_a = 1'b1; wr_data_a = 8'h22;
        @(negedge clk);
        wr_data_a = 8'h33;
        @(negedge clk);
        wr_en_a = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_tx_before_rst", 32'(tx_a), 32'd0);
        chk("t5_count_before_rst", 32'(count_a), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_tx_after_rst", 32'(tx_a), 32'd1);
        chk("t5_busy_after_rst", 32'(busy_a), 32'd0);
        chk("t5_count_after_rst", 32'(count_a), 32'd0);
        no_activity(0, 100, "t5");

        // Full-rate instance: 0x41 frame, 8680 cycles, decoded by mid-bit sampling.
        start_byte(1, 8'h41, "t6");
        capture(1, BB, f, bl, ba);
        chk("t6_frame", 32'(f), 32'h282);
        chk("t6_decoded_byte", 32'(f[8:1]), 32'h41);
        chk("t6_busy_cycle8679", 32'(bl), 32'd1);
        chk("t6_busy_cycle8680", 32'(ba), 32'd0);
        chk("t6_tx_idle", 32'(tx_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
